// File: rtl/dump_ctrl_pkg.sv
// Shared types and helpers for the capture-buffer dump controller.
package dump_pkg;

    // Controller sequence: calibration fetch, then one RD_RAM..NEXT loop per sample.
    typedef enum logic [3:0] {
        IDLE,
        REQ_GAIN,
        WAIT_GAIN,
        REQ_OFF,
        WAIT_OFF,
        RD_RAM,
        LATCH,
        SEND,
        NEXT,
        DONE
    } dump_state_t;

    // Widest channel index the calibration address helper accepts.
    localparam int CAL_CH_MAX_W = 8;

    // EEPROM calibration address: even word is gain, odd word is offset.
    function automatic logic [CAL_CH_MAX_W:0] cal_addr(input logic [CAL_CH_MAX_W-1:0] ch,
                                                        input logic                    is_offset);
        return {ch, is_offset};
    endfunction

    // Clip a signed value into the unsigned range [0, 2^w - 1].
    function automatic int sat_u(input int v, input int w);
        int max_v;
        max_v = (1 << w) - 1;
        if (v < 0) begin
            return 0;
        end
        if (v > max_v) begin
            return max_v;
        end
        return v;
    endfunction

endpackage

// File: rtl/dump_ctrl_if.sv
// Bus bundle between the dump controller and its neighbours
// (command processor, capture RAMs, SPI EEPROM master, UART TX).
interface dump_ctrl_if #(
    parameter int NUM_CH = 3,
    parameter int ADDR_W = 9,
    parameter int DATA_W = 8
);
    localparam int CH_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

    // command processor
    logic              start_dump;
    logic [CH_W-1:0]   channel;
    logic [ADDR_W-1:0] start_addr;
    logic              abort;
    logic              busy;
    logic              dump_done;
    logic              cmd_err;
    // capture RAMs
    logic [CH_W-1:0]   ch_sel;
    logic [ADDR_W-1:0] ram_addr;
    logic              ram_rd_en;
    logic [DATA_W-1:0] ram_rdata;
    // SPI EEPROM
    logic              eep_rd;
    logic [CH_W:0]     eep_addr;
    logic              eep_rdy;
    logic [DATA_W-1:0] eep_data;
    // UART TX
    logic [DATA_W-1:0] tx_data;
    logic              tx_start;
    logic              tx_rdy;

    // Controller side.
    modport master (
        input  start_dump, channel, start_addr, abort,
        input  ram_rdata, eep_rdy, eep_data, tx_rdy,
        output busy, dump_done, cmd_err,
        output ch_sel, ram_addr, ram_rd_en,
        output eep_rd, eep_addr,
        output tx_data, tx_start
    );

    // Environment side.
    modport slave (
        output start_dump, channel, start_addr, abort,
        output ram_rdata, eep_rdy, eep_data, tx_rdy,
        input  busy, dump_done, cmd_err,
        input  ch_sel, ram_addr, ram_rd_en,
        input  eep_rd, eep_addr,
        input  tx_data, tx_start
    );

endinterface

// File: rtl/dump_ctrl_cal_correct.sv
// Combinational sample correction: add signed offset, clip, scale by
// unsigned Q1.(DATA_W-1) gain, clip again. Intermediates are held in int,
// so DATA_W must stay at or below 15.
module cal_correct
    import dump_pkg::*;
#(
    parameter int DATA_W = 8
) (
    input  logic [DATA_W-1:0] sample,
    input  logic [DATA_W-1:0] gain,
    input  logic [DATA_W-1:0] offset,
    output logic [DATA_W-1:0] result
);

    logic signed [DATA_W+1:0] sum;
    logic [DATA_W-1:0]        sum_clip;
    logic [2*DATA_W-1:0]      prod;
    int                       sum_sat;
    int                       prod_sat;

    // Offset first (two extra bits cover both overflow and underflow), then gain.
    always_comb begin
        sum      = $signed({2'b00, sample}) + $signed({{2{offset[DATA_W-1]}}, offset});
        sum_sat  = sat_u(int'(sum), DATA_W);
        sum_clip = sum_sat[DATA_W-1:0];
        prod     = {{DATA_W{1'b0}}, sum_clip} * {{DATA_W{1'b0}}, gain};
        prod_sat = sat_u(int'(prod >> (DATA_W - 1)), DATA_W);
        result   = prod_sat[DATA_W-1:0];
    end

endmodule

// File: rtl/dump_ctrl.sv
// Capture-buffer dump controller: fetch per-channel calibration from the
// EEPROM, then stream DEPTH corrected samples from the circular capture RAM
// to the UART, starting at the requested address.
module dump_ctrl
    import dump_pkg::*;
#(
    parameter int NUM_CH = 3,
    parameter int ADDR_W = 9,
    parameter int DATA_W = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    dump_ctrl_if.master  bus
);

    localparam int                CH_W     = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
    localparam logic [ADDR_W-1:0] LAST_CNT = '1;  // DEPTH-1

    dump_state_t       state_q, state_d;
    logic [CH_W-1:0]   ch_sel_q, ch_sel_d;
    logic [ADDR_W-1:0] ptr_q, ptr_d;
    logic [ADDR_W-1:0] cnt_q, cnt_d;
    logic [DATA_W-1:0] gain_q, gain_d;
    logic [DATA_W-1:0] offset_q, offset_d;
    logic [DATA_W-1:0] tx_data_q, tx_data_d;
    logic              busy_q, busy_d;

    logic              ch_valid;
    logic [DATA_W-1:0] corrected;
    logic              is_offset;
    logic [CAL_CH_MAX_W:0] cal_full;
    logic              eep_rd;
    logic              ram_rd_en;
    logic              tx_start;
    logic              dump_done;
    logic              cmd_err;

    assign ch_valid = (int'(bus.channel) < NUM_CH);

    cal_correct #(
        .DATA_W (DATA_W)
    ) u_cal_correct (
        .sample (bus.ram_rdata),
        .gain   (gain_q),
        .offset (offset_q),
        .result (corrected)
    );

    // State, counters and calibration registers.
    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: every flop here is assigned with <=, so all of them see the
        // pre-edge values of each other regardless of statement order.
        if (!rst_n) begin
            state_q   <= IDLE;
            ch_sel_q  <= '0;
            ptr_q     <= '0;
            cnt_q     <= '0;
            gain_q    <= '0;
            offset_q  <= '0;
            tx_data_q <= '0;
            busy_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            ch_sel_q  <= ch_sel_d;
            ptr_q     <= ptr_d;
            cnt_q     <= cnt_d;
            gain_q    <= gain_d;
            offset_q  <= offset_d;
            tx_data_q <= tx_data_d;
            busy_q    <= busy_d;
        end
    end

    // Next-state logic and the one-cycle strobes decoded from the current state.
    always_comb begin
        // NOTE: defaults first so no path through the case leaves a signal
        // unassigned, which would otherwise infer a latch.
        state_d   = state_q;
        ch_sel_d  = ch_sel_q;
        ptr_d     = ptr_q;
        cnt_d     = cnt_q;
        gain_d    = gain_q;
        offset_d  = offset_q;
        tx_data_d = tx_data_q;
        is_offset = 1'b0;
        eep_rd    = 1'b0;
        ram_rd_en = 1'b0;
        tx_start  = 1'b0;
        dump_done = 1'b0;
        cmd_err   = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (bus.start_dump) begin
                    if (!ch_valid) begin
                        cmd_err = 1'b1;
                    end else begin
                        ch_sel_d = bus.channel;
                        ptr_d    = bus.start_addr;
                        cnt_d    = '0;
                        state_d  = REQ_GAIN;
                    end
                end
            end
            REQ_GAIN: begin
                eep_rd  = 1'b1;
                state_d = WAIT_GAIN;
            end
            WAIT_GAIN: begin
                if (bus.eep_rdy) begin
                    gain_d  = bus.eep_data;
                    state_d = REQ_OFF;
                end
            end
            REQ_OFF: begin
                is_offset = 1'b1;
                eep_rd    = 1'b1;
                state_d   = WAIT_OFF;
            end
            WAIT_OFF: begin
                is_offset = 1'b1;
                if (bus.eep_rdy) begin
                    offset_d = bus.eep_data;
                    state_d  = RD_RAM;
                end
            end
            RD_RAM: begin
                ram_rd_en = 1'b1;
                state_d   = LATCH;
            end
            LATCH: begin
                tx_data_d = corrected;
                state_d   = SEND;
            end
            SEND: begin
                if (bus.tx_rdy) begin
                    tx_start = 1'b1;
                    state_d  = NEXT;
                end
            end
            NEXT: begin
                if (cnt_q == LAST_CNT) begin
                    state_d = DONE;
                end else begin
                    ptr_d   = ptr_q + ADDR_W'(1);
                    cnt_d   = cnt_q + ADDR_W'(1);
                    state_d = RD_RAM;
                end
            end
            DONE: begin
                dump_done = 1'b1;
                state_d   = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // Abort wins over every transition except a byte launched this cycle,
        // which the UART has already taken.
        if (state_q != IDLE && bus.abort) begin
            state_d   = IDLE;
            eep_rd    = 1'b0;
            dump_done = 1'b0;
        end

        busy_d = (state_d != IDLE);
    end

    assign cal_full      = cal_addr(CAL_CH_MAX_W'(ch_sel_q), is_offset);
    assign bus.eep_addr  = cal_full[CH_W:0];
    assign bus.eep_rd    = eep_rd;
    assign bus.ch_sel    = ch_sel_q;
    assign bus.ram_addr  = ptr_q;
    assign bus.ram_rd_en = ram_rd_en;
    assign bus.tx_data   = tx_data_q;
    assign bus.tx_start  = tx_start;
    assign bus.busy      = busy_q;
    assign bus.dump_done = dump_done;
    assign bus.cmd_err   = cmd_err;

endmodule

// File: tb/tb_dump_ctrl.sv
// Directed bench for dump_ctrl with small RAM, EEPROM and UART models.
module tb_dump_ctrl;

    localparam int NUM_CH = 3;
    localparam int ADDR_W = 4;
    localparam int DATA_W = 8;
    localparam int DEPTH  = 16;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    dump_ctrl_if #(.NUM_CH(NUM_CH), .ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

    dump_ctrl #(.NUM_CH(NUM_CH), .ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    logic [7:0] ram [4][DEPTH];
    logic [7:0] cal [8];

    int   cyc = 0;
    int   n_launch;
    int   hold_on_byte = -1;
    int   abort_idx = -1;
    int   hold_cnt;
    int   uart_cnt;
    int   eep_cnt;
    logic [2:0] eep_addr_lat;
    logic abort_tb = 1'b0;

    int   n_checks = 0;
    int   n_fail = 0;

    logic [7:0] tx_q[$];
    int         tx_t[$];
    logic [3:0] addr_q[$];
    logic [2:0] eep_q[$];
    int         eep_t[$];
    int         done_cnt;
    int         err_cnt;
    bit         busy_seen;
    int         start_cyc;

    // Abort can be tied to a specific launch so it lands in the tx_start cycle.
    assign bus.abort = abort_tb | (bus.tx_start && (n_launch == abort_idx));

    always @(posedge clk) cyc <= cyc + 1;

    // Capture RAM: synchronous read, data one cycle after the strobe.
    always @(posedge clk) begin
        if (bus.ram_rd_en) bus.ram_rdata <= ram[bus.ch_sel][bus.ram_addr];
    end

    // EEPROM: answers three cycles after a request.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            eep_cnt      <= 0;
            eep_addr_lat <= '0;
            bus.eep_rdy  <= 1'b0;
            bus.eep_data <= '0;
        end else begin
            bus.eep_rdy <= 1'b0;
            if (bus.eep_rd) begin
                eep_cnt      <= 3;
                eep_addr_lat <= bus.eep_addr;
            end else if (eep_cnt > 0) begin
                eep_cnt <= eep_cnt - 1;
                if (eep_cnt == 1) begin
                    bus.eep_rdy  <= 1'b1;
                    bus.eep_data <= cal[eep_addr_lat];
                end
            end
        end
    end

    // UART: busy a few cycles per byte, plus an optional long stall after a chosen byte.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            uart_cnt   <= 0;
            hold_cnt   <= 0;
            n_launch   <= 0;
            bus.tx_rdy <= 1'b1;
        end else begin
            if (!bus.busy) n_launch <= 0;
            if (bus.tx_start) begin
                n_launch   <= n_launch + 1;
                uart_cnt   <= 3;
                bus.tx_rdy <= 1'b0;
                if (n_launch + 1 == hold_on_byte) hold_cnt <= 50;
            end else begin
                if (uart_cnt > 0) uart_cnt <= uart_cnt - 1;
                if (hold_cnt > 0) hold_cnt <= hold_cnt - 1;
                bus.tx_rdy <= (uart_cnt <= 1) && (hold_cnt <= 1);
            end
        end
    end

    // Monitor on the falling edge, away from the DUT's active edge.
    always @(negedge clk) begin
        if (bus.tx_start) begin
            tx_q.push_back(bus.tx_data);
            tx_t.push_back(cyc);
        end
        if (bus.ram_rd_en) addr_q.push_back(bus.ram_addr);
        if (bus.eep_rd) begin
            eep_q.push_back(bus.eep_addr);
            eep_t.push_back(cyc);
        end
        if (bus.dump_done) done_cnt++;
        if (bus.cmd_err) err_cnt++;
        if (bus.busy) busy_seen = 1'b1;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] out_vec();
        return {9'd0, bus.ch_sel, bus.ram_addr, bus.ram_rd_en, bus.eep_rd, bus.eep_addr,
                bus.tx_data, bus.tx_start, bus.busy, bus.dump_done, bus.cmd_err};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_log();
        tx_q.delete();
        tx_t.delete();
        addr_q.delete();
        eep_q.delete();
        eep_t.delete();
        done_cnt  = 0;
        err_cnt   = 0;
        busy_seen = 1'b0;
    endtask

    task automatic start_cmd(input int ch, input int addr);
        bus.start_dump = 1'b1;
        bus.channel    = 2'(ch);
        bus.start_addr = 4'(addr);
        start_cyc      = cyc;
        tick();
        bus.start_dump = 1'b0;
    endtask

    task automatic wait_idle(input string tag);
        int n;
        n = 0;
        do begin
            tick();
            n++;
        end while (bus.busy && n < 3000);
        check({tag, "_timeout"}, 32'(n < 3000), 1);
        repeat (3) tick();
    endtask

    task automatic set_ramp(input int ch, input int base);
        for (int i = 0; i < DEPTH; i++) ram[ch][i] = 8'(base + i);
    endtask

    initial begin
        bus.start_dump = 1'b0;
        bus.channel    = '0;
        bus.start_addr = '0;
        for (int i = 0; i < 8; i++) cal[i] = 8'h00;
        for (int c = 0; c < 4; c++) set_ramp(c, 0);
        clear_log();

        // Reset state.
        repeat (3) tick();
        check("rst_outputs_low", out_vec(), 0);
        rst_n = 1'b1;
        tick();
        check("post_rst_outputs", out_vec(), 0);

        // Unity gain, zero offset, channel 1, from address 0.
        cal[2] = 8'h80;
        cal[3] = 8'h00;
        set_ramp(1, 0);
        clear_log();
        start_cmd(1, 0);
        wait_idle("t1");
        check("t1_eep_rd_latency", 32'(eep_t[0] - start_cyc), 1);
        check("t1_eep_count", 32'(eep_q.size()), 2);
        check("t1_eep_gain_addr", 32'(eep_q[0]), 2);
        check("t1_eep_off_addr", 32'(eep_q[1]), 3);
        check("t1_byte_count", 32'(tx_q.size()), 16);
        for (int i = 0; i < DEPTH; i++) check($sformatf("t1_byte%0d", i), 32'(tx_q[i]), i);
        check("t1_done_pulses", 32'(done_cnt), 1);

        // Wrap from address 14; a second command mid-dump must be ignored.
        cal[0] = 8'h80;
        cal[1] = 8'h00;
        set_ramp(0, 8'h20);
        clear_log();
        start_cmd(0, 14);
        repeat (20) tick();
        start_cmd(2, 5);
        wait_idle("t2");
        check("t2_eep_count", 32'(eep_q.size()), 2);
        check("t2_addr_count", 32'(addr_q.size()), 16);
        for (int i = 0; i < DEPTH; i++) check($sformatf("t2_addr%0d", i), 32'(addr_q[i]), (14 + i) % 16);
        for (int i = 0; i < DEPTH; i++) check($sformatf("t2_byte%0d", i), 32'(tx_q[i]), 8'h20 + ((14 + i) % 16));
        check("t2_done_pulses", 32'(done_cnt), 1);

        // Saturation and scaling on channel 2, sample at address 0.
        cal[4] = 8'hFF;
        cal[5] = 8'h7F;
        ram[2][0] = 8'hF0;
        clear_log();
        start_cmd(2, 0);
        wait_idle("t3a");
        check("t3a_sat_high", 32'(tx_q[0]), 8'hFF);

        cal[4] = 8'h80;
        cal[5] = 8'h80;
        ram[2][0] = 8'h10;
        clear_log();
        start_cmd(2, 0);
        wait_idle("t3b");
        check("t3b_sat_low", 32'(tx_q[0]), 8'h00);

        cal[4] = 8'h40;
        cal[5] = 8'h00;
        ram[2][0] = 8'hC8;
        clear_log();
        start_cmd(2, 0);
        wait_idle("t3c");
        check("t3c_half_gain", 32'(tx_q[0]), 8'h64);

        // Invalid channel.
        clear_log();
        start_cmd(3, 0);
        repeat (8) tick();
        check("t4_cmd_err_pulses", 32'(err_cnt), 1);
        check("t4_no_eep_rd", 32'(eep_q.size()), 0);
        check("t4_busy_never", 32'(busy_seen), 0);

        // UART stall after byte 4, then abort on the launch of byte 9.
        hold_on_byte = 5;
        abort_idx    = 9;
        clear_log();
        start_cmd(1, 0);
        wait_idle("t5");
        check("t5_byte_count", 32'(tx_q.size()), 10);
        check("t5_stall_gap", 32'((tx_t[5] - tx_t[4]) >= 50), 1);
        check("t5_byte5", 32'(tx_q[5]), 5);
        check("t5_byte9", 32'(tx_q[9]), 9);
        check("t5_no_done", 32'(done_cnt), 0);
        check("t5_idle_after", 32'(bus.busy), 0);
        hold_on_byte = -1;
        abort_idx    = -1;

        // Reset while waiting in SEND, then a clean dump.
        hold_on_byte = 3;
        clear_log();
        start_cmd(1, 0);
        for (int n = 0; n < 500 && tx_q.size() < 3; n++) tick();
        repeat (10) tick();
        check("t6_bytes_before_rst", 32'(tx_q.size()), 3);
        rst_n = 1'b0;
        #1;
        check("t6_rst_async", out_vec(), 0);
        tick();
        check("t6_rst_edge", out_vec(), 0);
        hold_on_byte = -1;
        rst_n = 1'b1;
        tick();
        clear_log();
        start_cmd(1, 0);
        wait_idle("t6");
        check("t6_byte_count", 32'(tx_q.size()), 16);
        check("t6_byte0", 32'(tx_q[0]), 0);
        check("t6_byte15", 32'(tx_q[15]), 15);
        check("t6_done_pulses", 32'(done_cnt), 1);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
